// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave register bank: samples the SPI pins with clk, decodes a command
// byte plus burst data words, and exposes the registers as a flat bus.
//
// state  | meaning
// S_IDLE | nss high (or not yet seen high since reset); counters held
// S_CMD  | shifting in the 8-bit command/address byte
// S_DATA | shifting DATA_W-bit words; write commit or read shift-out per word
module spi_reg_bank #(
  parameter int NREGS  = 8,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    spi_clk,
  input  logic                    spi_mosi,
  input  logic                    spi_nss,
  output logic                    spi_miso,
  output logic                    spi_miso_oe,
  output logic [NREGS*DATA_W-1:0] regs,
  output logic                    wr_stb,
  output logic [6:0]              wr_addr
);

  localparam int SH_W = (DATA_W > 8) ? DATA_W : 8;
  localparam int CW   = 6;
  localparam logic [CW-1:0] CMD_LAST  = CW'(7);
  localparam logic [CW-1:0] WORD_LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DATA
  } state_t;

  state_t state_q, state_d;

  logic [2:0] sck_s;
  logic [1:0] mosi_s;
  logic [1:0] nss_s;
  logic       sck_rise, sck_fall, nss, mosi;
  logic       armed;

  logic [CW-1:0]     bit_cnt;
  logic [SH_W-2:0]   sh;
  logic [SH_W-1:0]   sh_next;
  logic              is_write;
  logic [6:0]        addr;
  logic [6:0]        addr_inc;
  logic              addr_valid;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rd_word;
  logic              cmd_done, word_done;

  logic [DATA_W-1:0] mem [NREGS];

  // nss sync resets low so a frame already running at reset release is never
  // mistaken for a fresh select; armed only sets once nss is really seen high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_s  <= '0;
      mosi_s <= '0;
      nss_s  <= '0;
      armed  <= 1'b0;
    end else begin
      sck_s  <= {sck_s[1:0], spi_clk};
      mosi_s <= {mosi_s[0], spi_mosi};
      nss_s  <= {nss_s[0], spi_nss};
      if (nss_s[1])
        armed <= 1'b1;
    end
  end

  assign sck_rise = sck_s[1] & ~sck_s[2];
  assign sck_fall = ~sck_s[1] & sck_s[2];
  assign nss      = nss_s[1];
  assign mosi     = mosi_s[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_done  = 1'b0;
    word_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!nss && armed)
          state_d = S_CMD;
      end
      S_CMD: begin
        if (nss) begin
          state_d = S_IDLE;
        end else if (sck_rise && bit_cnt == '0) begin
          state_d  = S_DATA;
          cmd_done = 1'b1;
        end
      end
      S_DATA: begin
        if (nss)
          state_d = S_IDLE;
        else if (sck_rise && bit_cnt == '0)
          word_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sh_next    = {sh, mosi};
  assign addr_valid = int'(addr) < NREGS;
  assign addr_inc   = (int'(addr) >= NREGS - 1) ? 7'd0 : addr + 7'd1;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NREGS; i++)
      if (int'(addr) == i)
        rd_word = mem[i];
  end

  // bit_cnt counts down to terminal 0; a rise at 0 closes the byte/word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt     <= '0;
      sh          <= '0;
      is_write    <= 1'b0;
      addr        <= '0;
      tx_sh       <= '0;
      spi_miso_oe <= 1'b0;
      wr_stb      <= 1'b0;
      wr_addr     <= '0;
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (state_q == S_IDLE || nss) begin
        bit_cnt     <= CMD_LAST;
        tx_sh       <= '0;
        spi_miso_oe <= 1'b0;
      end else begin
        if (sck_rise) begin
          sh <= sh_next[SH_W-2:0];
          if (cmd_done) begin
            is_write <= sh_next[7];
            addr     <= sh_next[6:0];
            bit_cnt  <= WORD_LAST;
          end else if (word_done) begin
            if (is_write && addr_valid) begin
              for (int i = 0; i < NREGS; i++)
                if (int'(addr) == i)
                  mem[i] <= sh_next[DATA_W-1:0];
              wr_stb  <= 1'b1;
              wr_addr <= addr;
            end
            addr    <= addr_inc;
            bit_cnt <= WORD_LAST;
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        // a fall while bit_cnt sits at WORD_LAST is the first fall of a word
        if (sck_fall && state_q == S_DATA && !is_write) begin
          spi_miso_oe <= 1'b1;
          if (bit_cnt == WORD_LAST)
            tx_sh <= rd_word;
          else
            tx_sh <= tx_sh << 1;
        end
      end
    end
  end

  assign spi_miso = spi_miso_oe & tx_sh[DATA_W-1];

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: writes, burst wrap, read-back, abort,
// out-of-range access and asynchronous reset in the middle of a frame.
module tb_spi_reg_bank;

  localparam int NREGS  = 8;
  localparam int DATA_W = 16;

  logic                    clk = 1'b0;
  logic                    rstn = 1'b0;
  logic                    spi_clk = 1'b0;
  logic                    spi_mosi = 1'b0;
  logic                    spi_nss = 1'b1;
  logic                    spi_miso;
  logic                    spi_miso_oe;
  logic [NREGS*DATA_W-1:0] regs;
  logic                    wr_stb;
  logic [6:0]              wr_addr;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0]  stb_addrs[$];
  logic [15:0] exp_regs[NREGS];
  logic [31:0] rd;

  spi_reg_bank #(.NREGS(NREGS), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_nss    (spi_nss),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .regs       (regs),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (wr_stb === 1'b1)
      stb_addrs.push_back(wr_addr);

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [31:0] data, input int nbits, output logic [31:0] got);
    got = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = data[i];
      wait_clk(6);
      got = {got[30:0], spi_miso};
      spi_clk = 1'b1;
      wait_clk(6);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    spi_nss = 1'b0;
    wait_clk(6);
  endtask

  task automatic spi_end();
    wait_clk(6);
    spi_nss = 1'b1;
    wait_clk(8);
  endtask

  task automatic test_reset();
    wait_clk(3);
    n_total++;
    if (regs !== '0) $display("FAIL reset_regs got %h want 0", regs); else n_pass++;
    n_total++;
    if (spi_miso !== 1'b0) $display("FAIL reset_miso got %b want 0", spi_miso); else n_pass++;
    n_total++;
    if (spi_miso_oe !== 1'b0) $display("FAIL reset_oe got %b want 0", spi_miso_oe); else n_pass++;
    n_total++;
    if (wr_stb !== 1'b0) $display("FAIL reset_wr_stb got %b want 0", wr_stb); else n_pass++;
    n_total++;
    if (wr_addr !== 7'd0) $display("FAIL reset_wr_addr got %0d want 0", wr_addr); else n_pass++;
    rstn = 1'b1;
    wait_clk(6);
    for (int i = 0; i < NREGS; i++) exp_regs[i] = '0;
  endtask

  task automatic test_single_write();
    stb_addrs.delete();
    spi_begin();
    spi_xfer(32'h83, 8, rd);
    spi_xfer(32'hBEEF, 16, rd);
    spi_end();
    exp_regs[3] = 16'hBEEF;
    for (int i = 0; i < NREGS; i++) begin
      n_total++;
      if (regs[i*DATA_W +: DATA_W] !== exp_regs[i])
        $display("FAIL single_write reg%0d got %h want %h", i, regs[i*DATA_W +: DATA_W], exp_regs[i]);
      else n_pass++;
    end
    n_total++;
    if (stb_addrs.size() != 1) $display("FAIL single_write stb_count got %0d want 1", stb_addrs.size());
    else n_pass++;
    n_total++;
    if (stb_addrs.size() < 1 || stb_addrs[0] !== 7'd3)
      $display("FAIL single_write wr_addr got %0d want 3", (stb_addrs.size() > 0) ? stb_addrs[0] : 7'h7f);
    else n_pass++;
  endtask

  task automatic test_burst_wrap();
    logic [6:0] want_addr[3];
    want_addr[0] = 7'd6; want_addr[1] = 7'd7; want_addr[2] = 7'd0;
    stb_addrs.delete();
    spi_begin();
    spi_xfer(32'h86, 8, rd);
    spi_xfer(32'h1111, 16, rd);
    spi_xfer(32'h2222, 16, rd);
    spi_xfer(32'h3333, 16, rd);
    spi_end();
    exp_regs[6] = 16'h1111;
    exp_regs[7] = 16'h2222;
    exp_regs[0] = 16'h3333;
    for (int i = 0; i < NREGS; i++) begin
      n_total++;
      if (regs[i*DATA_W +: DATA_W] !== exp_regs[i])
        $display("FAIL burst_wrap reg%0d got %h want %h", i, regs[i*DATA_W +: DATA_W], exp_regs[i]);
      else n_pass++;
    end
    n_total++;
    if (stb_addrs.size() != 3) $display("FAIL burst_wrap stb_count got %0d want 3", stb_addrs.size());
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (k >= stb_addrs.size() || stb_addrs[k] !== want_addr[k])
        $display("FAIL burst_wrap stb_addr%0d got %0d want %0d", k,
                 (k < stb_addrs.size()) ? stb_addrs[k] : 7'h7f, want_addr[k]);
      else n_pass++;
    end
  endtask

  task automatic test_read_back();
    stb_addrs.delete();
    spi_begin();
    spi_xfer(32'h0, 4, rd);
    n_total++;
    if (spi_miso_oe !== 1'b0) $display("FAIL read_oe_cmd got %b want 0", spi_miso_oe); else n_pass++;
    spi_xfer(32'h7, 4, rd);
    spi_xfer(32'h0, 16, rd);
    n_total++;
    if (rd[15:0] !== 16'h2222) $display("FAIL read_word0 got %h want 2222", rd[15:0]); else n_pass++;
    n_total++;
    if (spi_miso_oe !== 1'b1) $display("FAIL read_oe_data got %b want 1", spi_miso_oe); else n_pass++;
    spi_xfer(32'h0, 16, rd);
    n_total++;
    if (rd[15:0] !== 16'h3333) $display("FAIL read_word1 got %h want 3333", rd[15:0]); else n_pass++;
    spi_end();
    n_total++;
    if (spi_miso_oe !== 1'b0) $display("FAIL read_oe_after got %b want 0", spi_miso_oe); else n_pass++;
    n_total++;
    if (spi_miso !== 1'b0) $display("FAIL read_miso_after got %b want 0", spi_miso); else n_pass++;
    n_total++;
    if (stb_addrs.size() != 0) $display("FAIL read_no_stb got %0d want 0", stb_addrs.size());
    else n_pass++;
  endtask

  task automatic test_abort();
    stb_addrs.delete();
    spi_begin();
    spi_xfer(32'h82, 8, rd);
    spi_xfer(32'h1FF, 9, rd);
    spi_end();
    n_total++;
    if (regs[2*DATA_W +: DATA_W] !== exp_regs[2])
      $display("FAIL abort_reg2 got %h want %h", regs[2*DATA_W +: DATA_W], exp_regs[2]);
    else n_pass++;
    n_total++;
    if (stb_addrs.size() != 0) $display("FAIL abort_no_stb got %0d want 0", stb_addrs.size());
    else n_pass++;
    spi_begin();
    spi_xfer(32'h82, 8, rd);
    spi_xfer(32'h5A5A, 16, rd);
    spi_end();
    exp_regs[2] = 16'h5A5A;
    n_total++;
    if (regs[2*DATA_W +: DATA_W] !== 16'h5A5A)
      $display("FAIL abort_next_reg2 got %h want 5a5a", regs[2*DATA_W +: DATA_W]);
    else n_pass++;
    n_total++;
    if (stb_addrs.size() != 1 || stb_addrs[0] !== 7'd2)
      $display("FAIL abort_next_stb count %0d want 1 at addr 2", stb_addrs.size());
    else n_pass++;
  endtask

  task automatic test_out_of_range();
    stb_addrs.delete();
    spi_begin();
    spi_xfer(32'h90, 8, rd);
    spi_xfer(32'hAAAA, 16, rd);
    spi_end();
    for (int i = 0; i < NREGS; i++) begin
      n_total++;
      if (regs[i*DATA_W +: DATA_W] !== exp_regs[i])
        $display("FAIL oor_write reg%0d got %h want %h", i, regs[i*DATA_W +: DATA_W], exp_regs[i]);
      else n_pass++;
    end
    n_total++;
    if (stb_addrs.size() != 0) $display("FAIL oor_no_stb got %0d want 0", stb_addrs.size());
    else n_pass++;
    spi_begin();
    spi_xfer(32'h10, 8, rd);
    spi_xfer(32'hFFFF, 16, rd);
    n_total++;
    if (rd[15:0] !== 16'h0000) $display("FAIL oor_read got %h want 0000", rd[15:0]); else n_pass++;
    n_total++;
    if (spi_miso_oe !== 1'b1) $display("FAIL oor_read_oe got %b want 1", spi_miso_oe); else n_pass++;
    spi_end();
  endtask

  task automatic test_reset_mid_frame();
    stb_addrs.delete();
    spi_begin();
    spi_xfer(32'h81, 8, rd);
    spi_xfer(32'hFF, 8, rd);
    rstn = 1'b0;
    wait_clk(2);
    for (int i = 0; i < NREGS; i++) exp_regs[i] = '0;
    n_total++;
    if (regs !== '0) $display("FAIL rst_mid_regs got %h want 0", regs); else n_pass++;
    n_total++;
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || wr_stb !== 1'b0 || wr_addr !== 7'd0)
      $display("FAIL rst_mid_outputs got oe=%b miso=%b stb=%b addr=%0d want all 0",
               spi_miso_oe, spi_miso, wr_stb, wr_addr);
    else n_pass++;
    rstn = 1'b1;
    wait_clk(4);
    spi_xfer(32'hFF, 8, rd);
    spi_xfer(32'hABCD, 16, rd);
    spi_xfer(32'h81, 8, rd);
    spi_xfer(32'h4321, 16, rd);
    n_total++;
    if (regs !== '0) $display("FAIL rst_mid_ignored regs got %h want 0", regs); else n_pass++;
    n_total++;
    if (stb_addrs.size() != 0) $display("FAIL rst_mid_ignored_stb got %0d want 0", stb_addrs.size());
    else n_pass++;
    spi_end();
    spi_begin();
    spi_xfer(32'h81, 8, rd);
    spi_xfer(32'h1234, 16, rd);
    spi_end();
    exp_regs[1] = 16'h1234;
    for (int i = 0; i < NREGS; i++) begin
      n_total++;
      if (regs[i*DATA_W +: DATA_W] !== exp_regs[i])
        $display("FAIL rst_mid_after reg%0d got %h want %h", i, regs[i*DATA_W +: DATA_W], exp_regs[i]);
      else n_pass++;
    end
    n_total++;
    if (stb_addrs.size() != 1 || stb_addrs[0] !== 7'd1)
      $display("FAIL rst_mid_after_stb count %0d want 1 at addr 1", stb_addrs.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_wrap();
    test_read_back();
    test_abort();
    test_out_of_range();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
